// File: rtl/alu_nbit_seq.sv
// Registered WIDTH-bit ALU with start/busy/done handshake, status flags and an
// iterative shift-add multiplier. Same ALUOp encoding as the 1-bit slice.
module alu_nbit_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       ALUOp,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Result,
  output logic             CarryOut,
  output logic             Overflow,
  output logic             Zero
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {StIdle, StExec, StMult, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, prod_q, prod_d, result_q, result_d;
  logic [3:0]       op_q, op_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             carry_q, carry_d, ovf_q, ovf_d;

  // Combinational single-cycle ALU on the latched operands.
  logic [WIDTH-1:0] a_x, b_x, alu_res;
  logic [WIDTH:0]   sum;
  logic             cin_msb, add_ovf, alu_carry, alu_ovf;

  always_comb begin
    a_x       = op_q[3] ? ~a_q : a_q;
    b_x       = op_q[2] ? ~b_q : b_q;
    sum       = {1'b0, a_x} + {1'b0, b_x} + {{WIDTH{1'b0}}, op_q[2]};
    cin_msb   = sum[WIDTH-1] ^ a_x[WIDTH-1] ^ b_x[WIDTH-1];
    add_ovf   = cin_msb ^ sum[WIDTH];
    alu_res   = '0;
    alu_carry = 1'b0;
    alu_ovf   = 1'b0;
    case (op_q)
      4'b0000: alu_res = a_x & b_x;
      4'b0001: alu_res = a_x | b_x;
      4'b0010,
      4'b0110: begin
        alu_res   = sum[WIDTH-1:0];
        alu_carry = sum[WIDTH];
        alu_ovf   = add_ovf;
      end
      4'b0111: alu_res = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ add_ovf};
      4'b1100: alu_res = a_x & b_x;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    prod_d   = prod_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    carry_d  = carry_q;
    ovf_d    = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          op_d    = ALUOp;
          prod_d  = '0;
          cnt_d   = CntW'(WIDTH - 1);
          state_d = (ALUOp == 4'b1000) ? StMult : StExec;
        end
      end
      StExec: begin
        result_d = alu_res;
        carry_d  = alu_carry;
        ovf_d    = alu_ovf;
        state_d  = StDone;
      end
      StMult: begin
        // Counter wraps past zero into its extra MSB: that cycle commits the product.
        if (cnt_q[CntW-1]) begin
          result_d = prod_q;
          carry_d  = 1'b0;
          ovf_d    = 1'b0;
          state_d  = StDone;
        end else begin
          if (b_q[0]) prod_d = prod_q + a_q;
          a_d   = a_q << 1;
          b_d   = b_q >> 1;
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy     = (state_q != StIdle);
  assign done     = (state_q == StDone);
  assign Result   = result_q;
  assign CarryOut = carry_q;
  assign Overflow = ovf_q;
  assign Zero     = (result_q == '0);

endmodule

// File: tb/tb_alu_nbit_seq.sv
// Scoreboard bench for alu_nbit_seq at WIDTH=8: directed vectors push expected
// results, a negedge monitor pops and compares on every done pulse.
module tb_alu_nbit_seq;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic [3:0]   ALUOp = '0;
  logic         busy, done, CarryOut, Overflow, Zero;
  logic [W-1:0] Result;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string        name;
    logic [W-1:0] res;
    logic         c;
    logic         v;
    logic         z;
  } exp_t;

  exp_t sb_q[$];

  alu_nbit_seq #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .a        (a),
    .b        (b),
    .ALUOp    (ALUOp),
    .busy     (busy),
    .done     (done),
    .Result   (Result),
    .CarryOut (CarryOut),
    .Overflow (Overflow),
    .Zero     (Zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, got, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 want no pending op, Result=%0h", Result);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk({e.name, ".Result"},   32'(Result),   32'(e.res));
        chk({e.name, ".CarryOut"}, 32'(CarryOut), 32'(e.c));
        chk({e.name, ".Overflow"}, 32'(Overflow), 32'(e.v));
        chk({e.name, ".Zero"},     32'(Zero),     32'(e.z));
      end
    end
  end

  // Issue one op, expect done after exp_lat edges counting the sampling edge.
  // Optionally raise a second start at edge count inj_at while the op is running.
  task automatic issue(input string nm, input logic [3:0] op, input logic [W-1:0] aa,
                       input logic [W-1:0] bb, input logic [W-1:0] res, input logic c,
                       input logic v, input logic z, input int exp_lat, input int inj_at,
                       input logic [3:0] inj_op, input logic [W-1:0] inj_a,
                       input logic [W-1:0] inj_b);
    exp_t e;
    int   n;
    bit   got;
    e.name = nm;
    e.res  = res;
    e.c    = c;
    e.v    = v;
    e.z    = z;
    sb_q.push_back(e);
    start = 1'b1;
    ALUOp = op;
    a     = aa;
    b     = bb;
    @(posedge clk);
    n = 1;
    #1 start = 1'b0;
    got = 0;
    while (!got && n < 40) begin
      @(negedge clk);
      if (done === 1'b1) got = 1;
      else begin
        @(posedge clk);
        n++;
        #1;
        if (n == inj_at) begin
          start = 1'b1;
          ALUOp = inj_op;
          a     = inj_a;
          b     = inj_b;
        end else begin
          start = 1'b0;
        end
      end
    end
    if (got) chk({nm, ".latency"}, 32'(n), 32'(exp_lat));
    else begin
      n_tests++;
      n_fail++;
      $display("FAIL %s.timeout: got no done in %0d edges want %0d", nm, n, exp_lat);
    end
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish want finish before 100000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    chk("rst.Result", 32'(Result), 32'd0);
    chk("rst.Zero", 32'(Zero), 32'd1);
    chk("rst.CarryOut", 32'(CarryOut), 32'd0);
    chk("rst.Overflow", 32'(Overflow), 32'd0);
    #1 reset = 1'b0;

    // Reset held two cycles mid-MUL: no done, reset outputs afterwards
    @(posedge clk);
    #1 begin start = 1'b1; ALUOp = 4'b1000; a = 8'h0F; b = 8'h03; end
    @(posedge clk);
    #1 start = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("abort.busy", 32'(busy), 32'd0);
    chk("abort.Result", 32'(Result), 32'd0);
    chk("abort.Zero", 32'(Zero), 32'd1);
    repeat (14) @(negedge clk);
    chk("abort.busy_late", 32'(busy), 32'd0);
    @(posedge clk);
    #1;

    // ADD with start held into the DONE cycle; that start must be ignored
    issue("add_ff_01", 4'b0010, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1, 2, 2,
          4'b0010, 8'h11, 8'h22);
    @(negedge clk);
    chk("done_start_ignored.busy", 32'(busy), 32'd0);
    issue("add_7f_01", 4'b0010, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0, 2, 0, 4'h0, 8'h0, 8'h0);
    issue("sub_05_07", 4'b0110, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0, 1'b0, 2, 0, 4'h0, 8'h0, 8'h0);
    issue("slt_05_07", 4'b0111, 8'h05, 8'h07, 8'h01, 1'b0, 1'b0, 1'b0, 2, 0, 4'h0, 8'h0, 8'h0);
    issue("slt_80_01", 4'b0111, 8'h80, 8'h01, 8'h01, 1'b0, 1'b0, 1'b0, 2, 0, 4'h0, 8'h0, 8'h0);
    issue("slt_01_80", 4'b0111, 8'h01, 8'h80, 8'h00, 1'b0, 1'b0, 1'b1, 2, 0, 4'h0, 8'h0, 8'h0);
    issue("and_ca_0f", 4'b0000, 8'hCA, 8'h0F, 8'h0A, 1'b0, 1'b0, 1'b0, 2, 0, 4'h0, 8'h0, 8'h0);
    issue("or_ca_0f",  4'b0001, 8'hCA, 8'h0F, 8'hCF, 1'b0, 1'b0, 1'b0, 2, 0, 4'h0, 8'h0, 8'h0);
    issue("nor_ca_0f", 4'b1100, 8'hCA, 8'h0F, 8'h30, 1'b0, 1'b0, 1'b0, 2, 0, 4'h0, 8'h0, 8'h0);
    issue("illegal_f", 4'b1111, 8'hCA, 8'h0F, 8'h00, 1'b0, 1'b0, 1'b1, 2, 0, 4'h0, 8'h0, 8'h0);
    // MUL with an ADD 0C+0C start pulse (and operand change) mid-operation
    issue("mul_0d_0b", 4'b1000, 8'h0D, 8'h0B, 8'h8F, 1'b0, 1'b0, 1'b0, 10, 4,
          4'b0010, 8'h0C, 8'h0C);
    issue("mul_ff_ff", 4'b1000, 8'hFF, 8'hFF, 8'h01, 1'b0, 1'b0, 1'b0, 10, 0, 4'h0, 8'h0, 8'h0);
    issue("add_01_01", 4'b0010, 8'h01, 8'h01, 8'h02, 1'b0, 1'b0, 1'b0, 2, 0, 4'h0, 8'h0, 8'h0);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
